// File: rtl/mrd_chunk_scheduler.sv
// ============================================================================
// Module      : mrd_chunk_scheduler
// Description : Splits each read_chunk request into one or more PCIe MRd64
//               TLPs (two 64-bit beats each) on the TRN TX port. Assigns
//               request tags, caps unreleased tags, and acknowledges a chunk
//               once every TLP of it has been accepted by the endpoint.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   trn_clk_i                     user clock
//   reset_i                       synchronous, active-high reset
//   read_chunk_i                  chunk request level, held until ack
//   huge_page_addr_read_from_i    chunk byte address (sampled on first cycle)
//   read_chunk_ack_o              1-cycle pulse, whole chunk issued
//   cfg_completer_id_i            requester ID for DW1[31:16]
//   cpl_tag_release_i             1-cycle pulse, oldest tag released
//   trn_td_o / trn_trem_n_o       TX data / remainder (always full qword)
//   trn_tsof_n_o / trn_teof_n_o   start / end of frame, active-low
//   trn_tsrc_rdy_n_o              source ready, active-low
//   trn_tdst_rdy_n_i              destination ready, active-low
//   outstanding_o                 number of unreleased tags
//   err_release_underflow_o       sticky: release seen with nothing outstanding
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mrd_chunk_scheduler #(
  parameter int CHUNK_BYTES     = 512,
  parameter int RD_REQ_BYTES    = 512,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        trn_clk_i,
  input  logic        reset_i,
  input  logic        read_chunk_i,
  input  logic [63:0] huge_page_addr_read_from_i,
  output logic        read_chunk_ack_o,
  input  logic [15:0] cfg_completer_id_i,
  input  logic        cpl_tag_release_i,
  output logic [63:0] trn_td_o,
  output logic [7:0]  trn_trem_n_o,
  output logic        trn_tsof_n_o,
  output logic        trn_teof_n_o,
  output logic        trn_tsrc_rdy_n_o,
  input  logic        trn_tdst_rdy_n_i,
  output logic [5:0]  outstanding_o,
  output logic        err_release_underflow_o
);

  localparam int              NUM_REQ   = CHUNK_BYTES / RD_REQ_BYTES;
  localparam int              REM_W     = $clog2(NUM_REQ + 1);
  localparam logic [REM_W-1:0] NUM_REQ_L = REM_W'(NUM_REQ);
  localparam logic [9:0]      LEN       = 10'(RD_REQ_BYTES / 4);
  localparam logic [4:0]      TAG_LAST  = 5'(MAX_OUTSTANDING - 1);
  localparam logic [5:0]      MAX_OUT_L = 6'(MAX_OUTSTANDING);
  localparam logic [63:0]     ADDR_STEP = 64'(RD_REQ_BYTES);
  localparam logic [63:0]     ADDR_MASK = ~64'h3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_HDR0 = 3'd2,
    ST_HDR1 = 3'd3,
    ST_ACK  = 3'd4,
    ST_DROP = 3'd5
  } state_t;

  state_t           state_q;
  logic [63:0]      addr_q;
  logic [REM_W-1:0] rem_q;
  logic [4:0]       tag_q;
  logic [5:0]       out_q, out_d;
  logic             err_q, err_d;
  logic             ack_q;
  logic [63:0]      td_q;
  logic             sof_n_q;
  logic             eof_n_q;
  logic             srdy_n_q;

  logic             beat_xfer;
  logic             hdr1_xfer;
  logic [31:0]      dw0;
  logic [31:0]      dw1;

  assign beat_xfer = !srdy_n_q && !trn_tdst_rdy_n_i;
  assign hdr1_xfer = (state_q == ST_HDR1) && beat_xfer;

  // MRd64 header: Fmt/Type = 0b01_00000, no TC/attr bits, all byte enables set.
  assign dw0 = {1'b0, 7'b01_00000, 8'h00, 6'b0, LEN};
  assign dw1 = {cfg_completer_id_i, 3'b0, tag_q, 4'hF, 4'hF};

  // A new TLP and a release in the same cycle cancel out. A release with
  // nothing outstanding cannot go negative; it is flagged instead.
  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (hdr1_xfer && !cpl_tag_release_i) begin
      out_d = out_q + 6'd1;
    end else if (!hdr1_xfer && cpl_tag_release_i) begin
      if (out_q == 6'd0) begin
        err_d = 1'b1;
      end else begin
        out_d = out_q - 6'd1;
      end
    end
  end

  always_ff @(posedge trn_clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      addr_q   <= 64'd0;
      rem_q    <= '0;
      tag_q    <= 5'd0;
      out_q    <= 6'd0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      td_q     <= 64'd0;
      sof_n_q  <= 1'b1;
      eof_n_q  <= 1'b1;
      srdy_n_q <= 1'b1;
    end else begin
      out_q <= out_d;
      err_q <= err_d;
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Address is only valid in this first cycle; later changes are ignored.
          if (read_chunk_i) begin
            addr_q  <= huge_page_addr_read_from_i;
            rem_q   <= NUM_REQ_L;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Holds here indefinitely while every tag is in flight.
          if (out_q < MAX_OUT_L) begin
            td_q     <= {dw0, dw1};
            srdy_n_q <= 1'b0;
            sof_n_q  <= 1'b0;
            eof_n_q  <= 1'b1;
            state_q  <= ST_HDR0;
          end
        end
        ST_HDR0: begin
          if (beat_xfer) begin
            td_q    <= addr_q & ADDR_MASK;
            sof_n_q <= 1'b1;
            eof_n_q <= 1'b0;
            state_q <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (beat_xfer) begin
            // Source ready drops for a cycle between TLPs.
            srdy_n_q <= 1'b1;
            eof_n_q  <= 1'b1;
            tag_q    <= (tag_q == TAG_LAST) ? 5'd0 : tag_q + 5'd1;
            addr_q   <= addr_q + ADDR_STEP;
            rem_q    <= rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) begin
              ack_q   <= 1'b1;
              state_q <= ST_ACK;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_ACK: begin
          state_q <= ST_DROP;
        end
        ST_DROP: begin
          // Waiting for the request to fall keeps one ack per request.
          if (!read_chunk_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign read_chunk_ack_o        = ack_q;
  assign trn_td_o                = td_q;
  assign trn_trem_n_o            = 8'h00;
  assign trn_tsof_n_o            = sof_n_q;
  assign trn_teof_n_o            = eof_n_q;
  assign trn_tsrc_rdy_n_o        = srdy_n_q;
  assign outstanding_o           = out_q;
  assign err_release_underflow_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mrd_chunk_scheduler.sv
// ============================================================================
// Module      : tb_mrd_chunk_scheduler
// Description : Scoreboard bench for mrd_chunk_scheduler. Three instances:
//               dut0 default (512/512/4), dut1 RD_REQ_BYTES=128, dut2
//               MAX_OUTSTANDING=2. Expected beats are queued when a request
//               is issued; a negedge monitor pops and compares each transfer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mrd_chunk_scheduler;

  localparam int NDUT = 3;

  typedef struct packed {
    logic [63:0] td;
    logic        sof_n;
    logic        eof_n;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [NDUT];
  logic        rd_chunk [NDUT];
  logic [63:0] addr     [NDUT];
  logic        ack      [NDUT];
  logic        rel      [NDUT];
  logic [63:0] td       [NDUT];
  logic [7:0]  trem     [NDUT];
  logic        sof_n    [NDUT];
  logic        eof_n    [NDUT];
  logic        srdy_n   [NDUT];
  logic        drdy_n   [NDUT];
  logic [5:0]  outst    [NDUT];
  logic        err      [NDUT];
  logic [15:0] cid;

  beat_t exp_q [NDUT][$];
  int    xfer_cnt  [NDUT];
  int    ack_cnt   [NDUT];
  bit    prev_stall[NDUT];
  beat_t prev_beat [NDUT];
  beat_t cur_beat;
  beat_t exp_beat;
  int    n_checks = 0;
  int    n_fail   = 0;

  generate
    for (genvar k = 0; k < NDUT; k++) begin : g_dut
      mrd_chunk_scheduler #(
        .CHUNK_BYTES    (512),
        .RD_REQ_BYTES   ((k == 1) ? 128 : 512),
        .MAX_OUTSTANDING((k == 2) ? 2 : 4)
      ) u_dut (
        .trn_clk_i                 (clk),
        .reset_i                   (rst[k]),
        .read_chunk_i              (rd_chunk[k]),
        .huge_page_addr_read_from_i(addr[k]),
        .read_chunk_ack_o          (ack[k]),
        .cfg_completer_id_i        (cid),
        .cpl_tag_release_i         (rel[k]),
        .trn_td_o                  (td[k]),
        .trn_trem_n_o              (trem[k]),
        .trn_tsof_n_o              (sof_n[k]),
        .trn_teof_n_o              (eof_n[k]),
        .trn_tsrc_rdy_n_o          (srdy_n[k]),
        .trn_tdst_rdy_n_i          (drdy_n[k]),
        .outstanding_o             (outst[k]),
        .err_release_underflow_o   (err[k])
      );
    end
  endgenerate

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, required %0b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted beat with the scoreboard head, checks
  // that stalled beats hold still, and counts ack pulses.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      cur_beat = {td[k], sof_n[k], eof_n[k]};
      if (prev_stall[k]) begin
        chk64($sformatf("dut%0d stall td", k), cur_beat.td, prev_beat[k].td);
        chk1($sformatf("dut%0d stall sof_n", k), cur_beat.sof_n, prev_beat[k].sof_n);
        chk1($sformatf("dut%0d stall eof_n", k), cur_beat.eof_n, prev_beat[k].eof_n);
      end
      prev_stall[k] = !rst[k] && !srdy_n[k] && drdy_n[k];
      prev_beat[k]  = cur_beat;
      if (!rst[k] && !srdy_n[k] && !drdy_n[k]) begin
        xfer_cnt[k]++;
        if (exp_q[k].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut%0d unexpected beat: got %h, required no transfer", k, cur_beat.td);
        end else begin
          exp_beat = exp_q[k].pop_front();
          chk64($sformatf("dut%0d beat td", k), cur_beat.td, exp_beat.td);
          chk1($sformatf("dut%0d beat sof_n", k), cur_beat.sof_n, exp_beat.sof_n);
          chk1($sformatf("dut%0d beat eof_n", k), cur_beat.eof_n, exp_beat.eof_n);
          chk64($sformatf("dut%0d trem_n", k), {56'd0, trem[k]}, 64'd0);
        end
      end
      if (!rst[k] && ack[k]) ack_cnt[k]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tlp(input int k, input logic [63:0] b0, input logic [63:0] b1);
    exp_q[k].push_back({b0, 1'b0, 1'b1});
    exp_q[k].push_back({b1, 1'b1, 1'b0});
  endtask

  // sel 0: beat0 presented; 1: beat1 presented; 2: ack pulse
  task automatic wait_for(input int k, input int sel, input int budget, input string name);
    int  n   = 0;
    bit  hit = 1'b0;
    while (!hit && n < budget) begin
      tick();
      n++;
      case (sel)
        0:       hit = (srdy_n[k] == 1'b0) && (sof_n[k] == 1'b0);
        1:       hit = (srdy_n[k] == 1'b0) && (eof_n[k] == 1'b0);
        default: hit = (ack[k] == 1'b1);
      endcase
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL %s: event not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic do_chunk(input int k, input logic [63:0] a, input string name);
    addr[k]     = a;
    rd_chunk[k] = 1'b1;
    wait_for(k, 2, 60, name);
    rd_chunk[k] = 1'b0;
    tick();
    chk1({name, " ack single pulse"}, ack[k], 1'b0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          held;
    int          base;
    logic [63:0] t2_b0 [4];
    logic [63:0] t2_b1 [4];
    t2_b0 = '{64'h2000_0020_ABCD_00FF, 64'h2000_0020_ABCD_01FF,
              64'h2000_0020_ABCD_02FF, 64'h2000_0020_ABCD_03FF};
    t2_b1 = '{64'h0000_0002_0000_0000, 64'h0000_0002_0000_0080,
              64'h0000_0002_0000_0100, 64'h0000_0002_0000_0180};

    cid = 16'hABCD;
    for (int k = 0; k < NDUT; k++) begin
      rst[k] = 1'b1; rd_chunk[k] = 1'b0; addr[k] = 64'd0;
      rel[k] = 1'b0; drdy_n[k] = 1'b0;
      xfer_cnt[k] = 0; ack_cnt[k] = 0; prev_stall[k] = 1'b0;
    end
    repeat (3) tick();

    // Reset values
    chk1("reset ack", ack[0], 1'b0);
    chk1("reset tsrc_rdy_n", srdy_n[0], 1'b1);
    chk1("reset tsof_n", sof_n[0], 1'b1);
    chk1("reset teof_n", eof_n[0], 1'b1);
    chk64("reset td", td[0], 64'd0);
    chk64("reset trem_n", {56'd0, trem[0]}, 64'd0);
    chki("reset outstanding", int'(outst[0]), 0);
    chk1("reset err", err[0], 1'b0);
    for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;
    tick();

    // T1: single-TLP chunk, latency check; addr change after latch is ignored
    push_tlp(0, 64'h2000_0080_ABCD_00FF, 64'h0000_0001_2345_6000);
    addr[0]     = 64'h0000_0001_2345_6000;
    rd_chunk[0] = 1'b1;
    tick();
    addr[0] = 64'hDEAD_BEEF_0000_0000;
    chk1("T1 cycle1 no beat", srdy_n[0], 1'b1);
    tick();
    chk1("T1 cycle2 tsrc_rdy_n", srdy_n[0], 1'b0);
    chk1("T1 cycle2 tsof_n", sof_n[0], 1'b0);
    tick();
    chk1("T1 cycle3 tsof_n", sof_n[0], 1'b1);
    chk1("T1 cycle3 teof_n", eof_n[0], 1'b0);
    tick();
    chk1("T1 cycle4 ack", ack[0], 1'b1);
    chk1("T1 cycle4 tsrc_rdy_n", srdy_n[0], 1'b1);
    chki("T1 outstanding", int'(outst[0]), 1);
    rd_chunk[0] = 1'b0;
    tick();
    chk1("T1 ack single pulse", ack[0], 1'b0);
    tick();

    // T2: 128-byte requests, four TLPs per chunk, one ack
    for (int i = 0; i < 4; i++) push_tlp(1, t2_b0[i], t2_b1[i]);
    do_chunk(1, 64'h0000_0002_0000_0000, "T2");
    chki("T2 transfers", xfer_cnt[1], 8);
    chki("T2 acks", ack_cnt[1], 1);
    chki("T2 outstanding", int'(outst[1]), 4);

    // T3: cap of two tags; third chunk waits for a release
    push_tlp(2, 64'h2000_0080_ABCD_00FF, 64'h0000_0000_0000_1000);
    do_chunk(2, 64'h0000_0000_0000_1000, "T3 chunk1");
    push_tlp(2, 64'h2000_0080_ABCD_01FF, 64'h0000_0000_0000_1200);
    do_chunk(2, 64'h0000_0000_0000_1200, "T3 chunk2");
    chki("T3 outstanding at cap", int'(outst[2]), 2);
    push_tlp(2, 64'h2000_0080_ABCD_00FF, 64'h0000_0000_0000_1400);
    addr[2]     = 64'h0000_0000_0000_1400;
    rd_chunk[2] = 1'b1;
    held        = 1'b1;
    repeat (10) begin
      tick();
      if (srdy_n[2] !== 1'b1) held = 1'b0;
    end
    chk1("T3 held in WAIT", held, 1'b1);
    chki("T3 transfers while held", xfer_cnt[2], 4);
    rel[2] = 1'b1;
    tick();
    rel[2] = 1'b0;
    wait_for(2, 2, 20, "T3 ack after release");
    rd_chunk[2] = 1'b0;
    tick();
    tick();
    chki("T3 transfers", xfer_cnt[2], 6);
    chki("T3 outstanding", int'(outst[2]), 2);

    // T4: destination stalls 5 cycles on beat0, 3 cycles on beat1
    push_tlp(0, 64'h2000_0080_ABCD_01FF, 64'h0000_0000_0000_2000);
    base        = xfer_cnt[0];
    drdy_n[0]   = 1'b1;
    addr[0]     = 64'h0000_0000_0000_2000;
    rd_chunk[0] = 1'b1;
    wait_for(0, 0, 10, "T4 beat0");
    repeat (5) tick();
    drdy_n[0] = 1'b0;
    tick();
    chk1("T4 beat1 teof_n", eof_n[0], 1'b0);
    drdy_n[0] = 1'b1;
    repeat (3) tick();
    drdy_n[0] = 1'b0;
    wait_for(0, 2, 10, "T4 ack");
    rd_chunk[0] = 1'b0;
    tick();
    tick();
    chki("T4 transfers", xfer_cnt[0] - base, 2);
    chki("T4 outstanding", int'(outst[0]), 2);

    // T5: release coincident with HDR1 transfer; then underflow
    push_tlp(0, 64'h2000_0080_ABCD_02FF, 64'h0000_0000_0000_4000);
    addr[0]     = 64'h0000_0000_0000_4000;
    rd_chunk[0] = 1'b1;
    wait_for(0, 1, 10, "T5 beat1");
    rel[0] = 1'b1;
    tick();
    rel[0] = 1'b0;
    chk1("T5 ack", ack[0], 1'b1);
    chki("T5 outstanding unchanged", int'(outst[0]), 2);
    rd_chunk[0] = 1'b0;
    tick();
    tick();
    rel[0] = 1'b1;
    tick();
    chki("T5 release to 1", int'(outst[0]), 1);
    tick();
    rel[0] = 1'b0;
    chki("T5 release to 0", int'(outst[0]), 0);
    chk1("T5 no underflow yet", err[0], 1'b0);
    rel[0] = 1'b1;
    tick();
    rel[0] = 1'b0;
    chk1("T5 underflow set", err[0], 1'b1);
    chki("T5 outstanding floor", int'(outst[0]), 0);
    repeat (3) tick();
    chk1("T5 underflow sticky", err[0], 1'b1);

    // T6: reset during HDR1, request still high restarts with tag 0
    exp_q[0].push_back({64'h2000_0080_ABCD_03FF, 1'b0, 1'b1});
    addr[0]     = 64'h0000_0000_0000_6000;
    rd_chunk[0] = 1'b1;
    wait_for(0, 1, 10, "T6 beat1");
    drdy_n[0] = 1'b1;
    rst[0]    = 1'b1;
    addr[0]   = 64'h0000_0000_0000_8000;
    push_tlp(0, 64'h2000_0080_ABCD_00FF, 64'h0000_0000_0000_8000);
    tick();
    chk1("T6 tsrc_rdy_n after reset", srdy_n[0], 1'b1);
    chki("T6 outstanding after reset", int'(outst[0]), 0);
    chk1("T6 no ack", ack[0], 1'b0);
    chk1("T6 err cleared", err[0], 1'b0);
    rst[0]    = 1'b0;
    drdy_n[0] = 1'b0;
    wait_for(0, 2, 20, "T6 restart ack");
    rd_chunk[0] = 1'b0;
    tick();
    tick();
    chki("T6 outstanding", int'(outst[0]), 1);

    // Final scoreboard state
    chki("dut0 total acks", ack_cnt[0], 4);
    chki("dut1 total acks", ack_cnt[1], 1);
    chki("dut2 total acks", ack_cnt[2], 3);
    for (int k = 0; k < NDUT; k++)
      chki($sformatf("dut%0d beats left in scoreboard", k), exp_q[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
